// File: rtl/vx_sau_ctrl_pkg.sv
// Shared definitions for the systolic-array job sequencer: defaults, state encoding
// and the index helpers used to address packed N x N matrices.
package vx_sau_ctrl_pkg;

  localparam int DEF_MATRIX_SIZE = 2;
  localparam int DEF_DATA_SIZE   = 32;
  localparam int DEF_TAG_WIDTH   = 8;
  localparam int DEF_ARRAY_LAT   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FEED   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } sau_state_t;

  function automatic int feed_cycles(input int n);
    return 32'sd3 * n - 32'sd2;
  endfunction

  localparam int FEED_CYCLES = feed_cycles(DEF_MATRIX_SIZE);

  function automatic int elem_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  function automatic int cnt_width(input int n, input int lat);
    return $clog2(feed_cycles(n) + lat);
  endfunction

endpackage

// File: rtl/vx_sau_ctrl_if.sv
// Job request / result response bundle between a requester and the SAU sequencer.
interface vx_sau_ctrl_if
  import vx_sau_ctrl_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) ();

  localparam int MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_SIZE;

  logic                 req_valid;
  logic                 req_ready;
  logic [MAT_W-1:0]     req_a;
  logic [MAT_W-1:0]     req_b;
  logic [TAG_WIDTH-1:0] req_tag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [MAT_W-1:0]     rsp_c;
  logic [TAG_WIDTH-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_tag
  );

endinterface

// File: rtl/vx_sau_ctrl_skew.sv
// Diagonal skew selector: picks the operand element each array lane sees at feed step t.
module vx_sau_ctrl_skew
  import vx_sau_ctrl_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int CNT_W       = 3
) (
  input  logic                                           en,
  input  logic [CNT_W-1:0]                               t,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]   a_mat,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]   b_mat,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]               a_lanes,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]               b_lanes
);

  localparam int N = MATRIX_SIZE;
  localparam int D = DATA_SIZE;

  int k_s;

  // Lane l carries element k = t - l of its A row / B column; outside that window it idles at zero.
  always_comb begin
    a_lanes = '0;
    b_lanes = '0;
    k_s     = 0;
    for (int l = 0; l < N; l++) begin
      k_s = int'(t) - l;
      if (en && (k_s >= 0) && (k_s < N)) begin
        a_lanes[l*D +: D] = a_mat[elem_idx(l, k_s, N)*D +: D];
        b_lanes[l*D +: D] = b_mat[elem_idx(k_s, l, N)*D +: D];
      end else begin
        a_lanes[l*D +: D] = {D{1'b0}};
        b_lanes[l*D +: D] = {D{1'b0}};
      end
    end
  end

endmodule

// File: rtl/vx_sau_ctrl.sv
// Systolic-array job sequencer: accepts one matrix-multiply job, clears the array,
// streams skewed operands, waits for the pipeline to settle and returns the product.
module vx_sau_ctrl
  import vx_sau_ctrl_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int ARRAY_LAT   = DEF_ARRAY_LAT
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          abort,
  vx_sau_ctrl_if.slave                                  sau,
  output logic                                          arr_clear,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]              arr_a,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]              arr_b,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]  arr_out,
  output logic                                          busy,
  output logic [31:0]                                   jobs_done
);

  localparam int N     = MATRIX_SIZE;
  localparam int D     = DATA_SIZE;
  localparam int MAT_W = N * N * D;
  localparam int CNT_W = cnt_width(N, ARRAY_LAT);

  localparam logic [CNT_W-1:0] FEED_LAST   = CNT_W'(feed_cycles(N) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(ARRAY_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  sau_state_t           state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 accept_s, capture_s, abort_s, hs_s;

  logic [MAT_W-1:0]     a_mat_r, b_mat_r;
  logic [TAG_WIDTH-1:0] tag_r;
  logic                 arr_clear_r;
  logic [N*D-1:0]       arr_a_r, arr_b_r, skew_a_s, skew_b_s;
  logic                 rsp_valid_r;
  logic [MAT_W-1:0]     rsp_c_r;
  logic [TAG_WIDTH-1:0] rsp_tag_r;
  logic                 busy_r;
  logic [31:0]          jobs_done_r;

  // abort only acts on an in-flight job; a DONE handshake still counts even when aborted
  assign abort_s = abort && (state_r != ST_IDLE);
  assign hs_s    = (state_r == ST_DONE) && sau.rsp_ready;

  // Next-state and counter sequencing for the job FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    if (abort_s) begin
      state_s = ST_IDLE;
      cnt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sau.req_valid && !abort) begin
            accept_s = 1'b1;
            state_s  = ST_CLEAR;
          end else begin
            state_s  = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          state_s = ST_FEED;
          cnt_s   = '0;
        end
        ST_FEED: begin
          if (cnt_r == FEED_LAST) begin
            state_s = ST_SETTLE;
            cnt_s   = '0;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_s   = ST_DONE;
            capture_s = 1'b1;
            cnt_s     = '0;
          end else begin
            cnt_s     = cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (sau.rsp_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Operands are presented for the step about to be entered, so the registered lanes line up with FEED.
  vx_sau_ctrl_skew #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (D),
    .CNT_W       (CNT_W)
  ) u_skew (
    .en      (state_s == ST_FEED),
    .t       (cnt_s),
    .a_mat   (a_mat_r),
    .b_mat   (b_mat_r),
    .a_lanes (skew_a_s),
    .b_lanes (skew_b_s)
  );

  // FSM state, counter and job/result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      a_mat_r     <= '0;
      b_mat_r     <= '0;
      tag_r       <= '0;
      arr_clear_r <= 1'b0;
      arr_a_r     <= '0;
      arr_b_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_c_r     <= '0;
      rsp_tag_r   <= '0;
      busy_r      <= 1'b0;
      jobs_done_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      arr_clear_r <= (state_s == ST_CLEAR) || abort_s;
      arr_a_r     <= skew_a_s;
      arr_b_r     <= skew_b_s;
      rsp_valid_r <= (state_s == ST_DONE);
      busy_r      <= (state_s != ST_IDLE);

      if (accept_s) begin
        a_mat_r <= sau.req_a;
        b_mat_r <= sau.req_b;
        tag_r   <= sau.req_tag;
      end else if (abort_s) begin
        a_mat_r <= '0;
        b_mat_r <= '0;
        tag_r   <= '0;
      end else begin
        a_mat_r <= a_mat_r;
        b_mat_r <= b_mat_r;
        tag_r   <= tag_r;
      end

      if (capture_s) begin
        rsp_c_r   <= arr_out;
        rsp_tag_r <= tag_r;
      end else begin
        rsp_c_r   <= rsp_c_r;
        rsp_tag_r <= rsp_tag_r;
      end

      if (hs_s) begin
        jobs_done_r <= jobs_done_r + 32'd1;
      end else begin
        jobs_done_r <= jobs_done_r;
      end
    end
  end

  assign sau.req_ready = (state_r == ST_IDLE) && !abort;
  assign sau.rsp_valid = rsp_valid_r;
  assign sau.rsp_c     = rsp_c_r;
  assign sau.rsp_tag   = rsp_tag_r;
  assign arr_clear     = arr_clear_r;
  assign arr_a         = arr_a_r;
  assign arr_b         = arr_b_r;
  assign busy          = busy_r;
  assign jobs_done     = jobs_done_r;

endmodule

// File: tb/tb_vx_sau_ctrl.sv
// Scoreboard bench for vx_sau_ctrl with a behavioural output-stationary 2x2 array model.
module tb_vx_sau_ctrl;
  import vx_sau_ctrl_pkg::*;

  localparam int N = 2;
  localparam int D = 32;

  typedef struct packed {
    logic [127:0] c;
    logic [7:0]   tag;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          abort;
  logic          arr_clear;
  logic [63:0]   arr_a, arr_b;
  logic [127:0]  arr_out;
  logic          busy;
  logic [31:0]   jobs_done;

  int   n_vec  = 0;
  int   n_miss = 0;
  rsp_t sb_q[$];
  rsp_t mon_exp;
  int   exp_jobs = 0;

  logic [63:0] fa [4];
  logic [63:0] fb [4];

  vx_sau_ctrl_if #(.MATRIX_SIZE(N), .DATA_SIZE(D), .TAG_WIDTH(8)) sau_if ();

  vx_sau_ctrl #(.MATRIX_SIZE(N), .DATA_SIZE(D), .TAG_WIDTH(8), .ARRAY_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .sau       (sau_if.slave),
    .arr_clear (arr_clear),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .arr_out   (arr_out),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  always #5 clk = ~clk;

  // Array model: PE(i,j) takes A from the left and B from above, accumulating modulo 2^D.
  logic [D-1:0] pa [N][N];
  logic [D-1:0] pb [N][N];
  logic [D-1:0] acc [N][N];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!reset || arr_clear) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= (j == 0) ? arr_a[i*D +: D] : pa[i][(j == 0) ? 0 : j-1];
          pb[i][j]  <= (i == 0) ? arr_b[j*D +: D] : pb[(i == 0) ? 0 : i-1][j];
          acc[i][j] <= acc[i][j] +
                       ((j == 0) ? arr_a[i*D +: D] : pa[i][(j == 0) ? 0 : j-1]) *
                       ((i == 0) ? arr_b[j*D +: D] : pb[(i == 0) ? 0 : i-1][j]);
        end
      end
    end
  end

  always_comb begin
    arr_out = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        arr_out[(i*N+j)*D +: D] = acc[i][j];
  end

  function automatic logic [127:0] m2(input logic [31:0] e00, e01, e10, e11);
    return {e11, e10, e01, e00};
  endfunction

  function automatic logic [63:0] l2(input logic [31:0] lane0, lane1);
    return {lane1, lane0};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [127:0] a, input logic [127:0] b, input logic [7:0] tag);
    logic ok;
    ok = 1'b0;
    sau_if.req_a     = a;
    sau_if.req_b     = b;
    sau_if.req_tag   = tag;
    sau_if.req_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (sau_if.req_ready) ok = 1'b1;
      tick();
    end
    sau_if.req_valid = 1'b0;
    chk("accept", 128'(ok), 128'd1);
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 40 && !sau_if.rsp_valid; k++) tick();
    chk("rsp_wait", 128'(sau_if.rsp_valid), 128'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) tick();
    chk("idle_wait", 128'(busy), 128'd0);
  endtask

  // Monitor: every response handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (sau_if.rsp_valid && sau_if.rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rsp: got tag %h with no pending job", sau_if.rsp_tag);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("rsp_c", sau_if.rsp_c, mon_exp.c);
        chk("rsp_tag", 128'(sau_if.rsp_tag), 128'(mon_exp.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    abort = 1'b0;
    sau_if.req_valid = 1'b0;
    sau_if.req_a     = '0;
    sau_if.req_b     = '0;
    sau_if.req_tag   = '0;
    sau_if.rsp_ready = 1'b0;
    fa[0] = l2(32'd1, 32'd0); fb[0] = l2(32'd5, 32'd0);
    fa[1] = l2(32'd2, 32'd3); fb[1] = l2(32'd7, 32'd6);
    fa[2] = l2(32'd0, 32'd4); fb[2] = l2(32'd0, 32'd8);
    fa[3] = l2(32'd0, 32'd0); fb[3] = l2(32'd0, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(sau_if.req_ready), 128'd1);
    chk("rst_arr_clear", 128'(arr_clear), 128'd0);
    chk("rst_arr_a", 128'(arr_a), 128'd0);
    chk("rst_rsp_valid", 128'(sau_if.rsp_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_jobs", 128'(jobs_done), 128'd0);
    reset = 1'b1;
    tick();

    // Job 1: exact operand skew and latency
    sau_if.req_a = m2(32'd1, 32'd2, 32'd3, 32'd4);
    sau_if.req_b = m2(32'd5, 32'd6, 32'd7, 32'd8);
    sau_if.req_tag = 8'h5A;
    sau_if.rsp_ready = 1'b1;
    sb_q.push_back('{c: m2(32'd19, 32'd22, 32'd43, 32'd50), tag: 8'h5A});
    sau_if.req_valid = 1'b1;
    chk("j1_req_ready", 128'(sau_if.req_ready), 128'd1);
    tick();
    sau_if.req_valid = 1'b0;
    chk("j1_clear", 128'(arr_clear), 128'd1);
    chk("j1_busy", 128'(busy), 128'd1);
    chk("j1_req_ready_busy", 128'(sau_if.req_ready), 128'd0);
    for (int t = 0; t < FEED_CYCLES; t++) begin
      tick();
      chk("j1_arr_a", 128'(arr_a), 128'(fa[t]));
      chk("j1_arr_b", 128'(arr_b), 128'(fb[t]));
      chk("j1_feed_clear", 128'(arr_clear), 128'd0);
    end
    tick();
    chk("j1_settle_valid", 128'(sau_if.rsp_valid), 128'd0);
    chk("j1_settle_arr_a", 128'(arr_a), 128'd0);
    tick();
    chk("j1_edge6_valid", 128'(sau_if.rsp_valid), 128'd1);
    tick();
    exp_jobs = 1;
    chk("j1_jobs", 128'(jobs_done), 128'(exp_jobs));
    chk("j1_idle", 128'(busy), 128'd0);

    // Job 2: consumer stalls for 10 cycles in DONE
    sau_if.rsp_ready = 1'b0;
    sb_q.push_back('{c: m2(32'd18, 32'd16, 32'd14, 32'd12), tag: 8'h11});
    start_job(m2(32'd2, 32'd0, 32'd0, 32'd2), m2(32'd9, 32'd8, 32'd7, 32'd6), 8'h11);
    wait_rsp();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_valid", 128'(sau_if.rsp_valid), 128'd1);
      chk("stall_c", sau_if.rsp_c, m2(32'd18, 32'd16, 32'd14, 32'd12));
      chk("stall_req_ready", 128'(sau_if.req_ready), 128'd0);
    end
    sau_if.rsp_ready = 1'b1;
    tick();
    exp_jobs = 2;
    chk("stall_release_idle", 128'(busy), 128'd0);
    chk("stall_jobs", 128'(jobs_done), 128'(exp_jobs));

    // Jobs 3+4: back to back with req_valid held; first result wraps modulo 2^32
    sb_q.push_back('{c: m2(32'hFFFF_FFFE, 32'd0, 32'd0, 32'd3), tag: 8'hFF});
    sb_q.push_back('{c: m2(32'd4, 32'd6, 32'd4, 32'd6), tag: 8'h22});
    sau_if.req_a = m2(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1);
    sau_if.req_b = m2(32'd2, 32'd0, 32'd0, 32'd3);
    sau_if.req_tag = 8'hFF;
    sau_if.req_valid = 1'b1;
    tick();
    sau_if.req_a = m2(32'd1, 32'd1, 32'd1, 32'd1);
    sau_if.req_b = m2(32'd1, 32'd2, 32'd3, 32'd4);
    sau_if.req_tag = 8'h22;
    repeat (7) tick();
    chk("b2b_gap_idle", 128'(busy), 128'd0);
    chk("b2b_gap_ready", 128'(sau_if.req_ready), 128'd1);
    tick();
    sau_if.req_valid = 1'b0;
    chk("b2b_second_clear", 128'(arr_clear), 128'd1);
    wait_rsp();
    wait_idle();
    exp_jobs = 4;
    chk("b2b_jobs", 128'(jobs_done), 128'(exp_jobs));

    // Abort during FEED t=1
    start_job(m2(32'd1, 32'd2, 32'd3, 32'd4), m2(32'd5, 32'd6, 32'd7, 32'd8), 8'h77);
    tick();
    tick();
    chk("abort_t1_arr_a", 128'(arr_a), 128'(fa[1]));
    abort = 1'b1;
    tick();
    chk("abort_idle", 128'(busy), 128'd0);
    chk("abort_clear", 128'(arr_clear), 128'd1);
    chk("abort_arr_a", 128'(arr_a), 128'd0);
    chk("abort_arr_b", 128'(arr_b), 128'd0);
    chk("abort_no_rsp", 128'(sau_if.rsp_valid), 128'd0);
    chk("abort_req_ready", 128'(sau_if.req_ready), 128'd0);
    abort = 1'b0;
    tick();
    chk("abort_clear_pulse", 128'(arr_clear), 128'd0);
    repeat (8) tick();
    chk("abort_still_idle", 128'(sau_if.rsp_valid), 128'd0);
    chk("abort_jobs", 128'(jobs_done), 128'(exp_jobs));

    // Abort coincident with DONE handshake, then abort blocks acceptance in IDLE
    sau_if.rsp_ready = 1'b0;
    sb_q.push_back('{c: m2(32'd19, 32'd22, 32'd43, 32'd50), tag: 8'h44});
    start_job(m2(32'd1, 32'd2, 32'd3, 32'd4), m2(32'd5, 32'd6, 32'd7, 32'd8), 8'h44);
    wait_rsp();
    abort = 1'b1;
    sau_if.rsp_ready = 1'b1;
    tick();
    exp_jobs = 5;
    chk("abort_hs_jobs", 128'(jobs_done), 128'(exp_jobs));
    chk("abort_hs_idle", 128'(busy), 128'd0);
    chk("abort_hs_valid", 128'(sau_if.rsp_valid), 128'd0);
    sau_if.req_valid = 1'b1;
    chk("abort_idle_ready", 128'(sau_if.req_ready), 128'd0);
    tick();
    chk("abort_idle_noaccept", 128'(busy), 128'd0);
    abort = 1'b0;
    sau_if.req_valid = 1'b0;
    tick();

    // Asynchronous reset mid-SETTLE
    start_job(m2(32'd2, 32'd0, 32'd0, 32'd2), m2(32'd9, 32'd8, 32'd7, 32'd6), 8'h66);
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_valid", 128'(sau_if.rsp_valid), 128'd0);
    chk("arst_c", sau_if.rsp_c, 128'd0);
    chk("arst_tag", 128'(sau_if.rsp_tag), 128'd0);
    chk("arst_jobs", 128'(jobs_done), 128'd0);
    chk("arst_clear", 128'(arr_clear), 128'd0);
    chk("arst_arr_a", 128'(arr_a), 128'd0);
    chk("arst_req_ready", 128'(sau_if.req_ready), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    exp_jobs = 0;

    sau_if.rsp_ready = 1'b1;
    sb_q.push_back('{c: m2(32'd3, 32'd3, 32'd1, 32'd9), tag: 8'h33});
    start_job(m2(32'd3, 32'd0, 32'd1, 32'd2), m2(32'd1, 32'd1, 32'd0, 32'd4), 8'h33);
    wait_rsp();
    wait_idle();
    exp_jobs = 1;
    chk("post_rst_jobs", 128'(jobs_done), 128'(exp_jobs));

    repeat (2) tick();
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
